// File: rtl/iram_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
`ifndef XLEN
`define XLEN 32
`endif

package iram_responder_pkg;

    typedef enum logic [1:0] {
        IRAM_ST_IDLE = 2'd0,
        IRAM_ST_WAIT = 2'd1,
        IRAM_ST_RESP = 2'd2
    } iram_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/iram_array.sv
// Instruction word array: one synchronous read port, one write port, read-before-write.
module iram_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Holds its value between reads; this register is the visible inst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/iram_responder.sv
// Instruction-memory responder for the IF stage: wait-state FSM over iram_array.
// Optional macro IRAM_BUS_ERR_EN adds the inst_err output for out-of-range fetches.
`ifndef XLEN
`define XLEN 32
`endif

module iram_responder
    import iram_responder_pkg::*;
#(
    parameter int                DEPTH       = 4096,
    parameter int                AW          = $clog2(DEPTH),
    parameter int                WAIT_CYCLES = 0,
    parameter logic [`XLEN-1:0]  NOP_INST    = INST_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iram_en,
    input  logic [`XLEN-1:0]  inst_raddr,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic [`XLEN-1:0]  inst,
    output logic              fetch_hand_suc,
    output logic              iram_busy,
    input  logic              wr_en,
    input  logic [`XLEN-1:0]  wr_addr,
    input  logic [`XLEN-1:0]  wr_data,
    output logic [1:0]        state_dbg
`ifdef IRAM_BUS_ERR_EN
    ,
    output logic              inst_err
`endif
);

    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    iram_state_t      state;
    logic [3:0]       wait_cnt;
    logic [AW-1:0]    idx_q;
    logic             oor_q;
    logic             rsp_oor;
    logic [AW-1:0]    req_idx;
    logic             req_oor;
    logic             wr_oor;
    logic             accept;
    logic             wait_done;
    logic             rd_en;
    logic [AW-1:0]    rd_idx;
    logic [`XLEN-1:0] rd_data;
    logic             unused_low_bits;

    assign req_idx = inst_raddr[AW+1:2];
    assign req_oor = |inst_raddr[`XLEN-1:AW+2];
    assign wr_oor  = |wr_addr[`XLEN-1:AW+2];
    assign unused_low_bits = ^{inst_raddr[1:0], wr_addr[1:0]};

    // A redirect (flush with iram_en) is taken in any state; otherwise a new
    // request is only taken when idle or when the current response is consumed.
    assign accept    = iram_en && ((state == IRAM_ST_IDLE) || flush ||
                                   ((state == IRAM_ST_RESP) && !pipe_stall));
    assign wait_done = (state == IRAM_ST_WAIT) && !flush && (wait_cnt == 4'd1);
    assign rd_en     = (accept && NO_WAIT) || wait_done;
    assign rd_idx    = accept ? req_idx : idx_q;

    iram_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (`XLEN)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en && !wr_oor),
        .wr_idx  (wr_addr[AW+1:2]),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IRAM_ST_IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            rsp_oor  <= 1'b0;
        end else if (accept) begin
            idx_q    <= req_idx;
            oor_q    <= req_oor;
            wait_cnt <= 4'(WAIT_CYCLES);
            if (NO_WAIT) begin
                state   <= IRAM_ST_RESP;
                rsp_oor <= req_oor;
            end else begin
                state   <= IRAM_ST_WAIT;
            end
        end else if (flush) begin
            state    <= IRAM_ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IRAM_ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state    <= IRAM_ST_RESP;
                        rsp_oor  <= oor_q;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                IRAM_ST_RESP: begin
                    if (!pipe_stall) begin
                        state <= IRAM_ST_IDLE;
                    end
                end
                IRAM_ST_IDLE: ;
                default: state <= IRAM_ST_IDLE;
            endcase
        end
    end

    // Handshake: in RESP, inst is valid; the IF stage is ready when pipe_stall
    // is low, and fetch_hand_suc marks the single cycle where both hold
    // (a flush in the same cycle kills the transfer).
    assign fetch_hand_suc = (state == IRAM_ST_RESP) && !pipe_stall && !flush;
    assign iram_busy      = (state != IRAM_ST_IDLE);
    assign inst           = rsp_oor ? NOP_INST : rd_data;
    assign state_dbg      = state;

`ifdef IRAM_BUS_ERR_EN
    assign inst_err = fetch_hand_suc && rsp_oor;
`endif

endmodule

// File: tb/tb_iram_responder.sv
// Bench for iram_responder: three instances (0, 2 and 3 wait states) and a scoreboard.
module tb_iram_responder;
    import iram_responder_pkg::*;

    localparam int NI  = 3;
    localparam int SBW = 67;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BB[3] = '{32'h0010_0113, 32'h0020_0193, 32'h0030_0213};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        en    [NI];
    logic [31:0] raddr [NI];
    logic        fl    [NI];
    logic        st    [NI];
    logic        we    [NI];
    logic [31:0] wa    [NI];
    logic [31:0] wd    [NI];
    logic [31:0] inst_o[NI];
    logic        suc   [NI];
    logic        busy  [NI];
    logic [1:0]  dbg   [NI];
`ifdef IRAM_BUS_ERR_EN
    logic        err_o [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        iram_responder #(
            .WAIT_CYCLES (g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .iram_en        (en[g]),
            .inst_raddr     (raddr[g]),
            .flush          (fl[g]),
            .pipe_stall     (st[g]),
            .inst           (inst_o[g]),
            .fetch_hand_suc (suc[g]),
            .iram_busy      (busy[g]),
            .wr_en          (we[g]),
            .wr_addr        (wa[g]),
            .wr_data        (wd[g]),
            .state_dbg      (dbg[g])
`ifdef IRAM_BUS_ERR_EN
            ,
            .inst_err       (err_o[g])
`endif
        );
    end

    // Entry: {err[66], port[65:64], handshake cycle[63:32], inst[31:0]}
    logic [SBW-1:0] exp_q[$];
    logic [SBW-1:0] mon_e;
    int checks   = 0;
    int failures = 0;
    logic [31:0] shadow[16];
    int w;

    function automatic int wc(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
        we[k] = 1'b1;
        wa[k] = a;
        wd[k] = d;
        tick();
        we[k] = 1'b0;
    endtask

    // Called right after a clock edge; the request is taken on the next edge.
    task automatic push(input int k, input logic [31:0] data, input logic err, input int extra);
        logic [SBW-1:0] e;
        e = {err, 2'(k), 32'(cyc + 1 + wc(k) + extra), data};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < NI; k++) begin
                if (suc[k]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_suc", 32'(suc[k]), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_port", k, 32'(mon_e[65:64]));
                        check("sb_inst", inst_o[k], mon_e[31:0]);
                        check("sb_cycle", cyc, mon_e[63:32]);
`ifdef IRAM_BUS_ERR_EN
                        check("sb_inst_err", 32'(err_o[k]), 32'(mon_e[66]));
`endif
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b0; raddr[k] = '0; fl[k] = 1'b0; st[k] = 1'b0;
            we[k] = 1'b0; wa[k] = '0; wd[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_inst", inst_o[k], 32'd0);
            check("rst_suc", 32'(suc[k]), 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_state", 32'(dbg[k]), 32'(IRAM_ST_IDLE));
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero wait states: single fetch after a load
        load(0, 32'h10, 32'h00A0_0093);
        idle(2);
        en[0] = 1'b1; raddr[0] = 32'h10; push(0, 32'h00A0_0093, 1'b0, 0);
        tick();
        en[0] = 1'b0;
        idle(3);

        // Back-to-back fetches with iram_en held
        for (int i = 0; i < 3; i++) load(0, 32'(4 * i), BB[i]);
        for (int i = 0; i < 3; i++) begin
            en[0] = 1'b1; raddr[0] = 32'(4 * i); push(0, BB[i], 1'b0, 0);
            tick();
        end
        en[0] = 1'b0;
        idle(3);

        // Stall held for three cycles in RESP
        en[0] = 1'b1; st[0] = 1'b1; raddr[0] = 32'h10; push(0, 32'h00A0_0093, 1'b0, 3);
        tick();
        en[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_inst", inst_o[0], 32'h00A0_0093);
            check("stall_suc", 32'(suc[0]), 32'd0);
            check("stall_busy", 32'(busy[0]), 32'd1);
        end
        @(posedge clk);
        #1 st[0] = 1'b0;
        idle(3);

        // Same-word write and read in one cycle returns the old word
        en[0] = 1'b1; raddr[0] = 32'h10; push(0, 32'h00A0_0093, 1'b0, 0);
        we[0] = 1'b1; wa[0] = 32'h10; wd[0] = 32'h0050_0293;
        tick();
        en[0] = 1'b0; we[0] = 1'b0;
        idle(1);

        // Out-of-range write must not alias onto word 4
        load(0, 32'h0001_0010, 32'hDEAD_BEEF);
        en[0] = 1'b1; raddr[0] = 32'h12; push(0, 32'h0050_0293, 1'b0, 0);
        tick();
        en[0] = 1'b0;
        idle(2);

        // Out-of-range read
        en[0] = 1'b1; raddr[0] = 32'h0001_0000; push(0, NOP, 1'b1, 0);
        tick();
        en[0] = 1'b0;
        idle(2);

        // Two wait states: busy for three cycles, handshake in the last
        load(1, 32'h10, 32'h00A0_0093);
        idle(1);
        en[1] = 1'b1; raddr[1] = 32'h10; push(1, 32'h00A0_0093, 1'b0, 0);
        tick();
        en[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w2_busy", 32'(busy[1]), (i < 3) ? 32'd1 : 32'd0);
            if (i < 2) check("w2_state", 32'(dbg[1]), 32'(IRAM_ST_WAIT));
        end
        tick();

        // Three wait states: redirect during WAIT replaces the pending fetch
        load(2, 32'h10, 32'h00A0_0093);
        load(2, 32'h40, 32'h0400_0313);
        en[2] = 1'b1; raddr[2] = 32'h10;
        tick();
        en[2] = 1'b0;
        fl[2] = 1'b1; en[2] = 1'b1; raddr[2] = 32'h40; push(2, 32'h0400_0313, 1'b0, 0);
        tick();
        fl[2] = 1'b0; en[2] = 1'b0;
        @(negedge clk);
        check("w3_redirect_state", 32'(dbg[2]), 32'(IRAM_ST_WAIT));
        idle(8);

        // Asynchronous reset in the middle of WAIT
        en[1] = 1'b1; raddr[1] = 32'h10;
        tick();
        en[1] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy[1]), 32'd0);
        check("arst_inst", inst_o[1], 32'd0);
        check("arst_suc", 32'(suc[1]), 32'd0);
        check("arst_state", 32'(dbg[1]), 32'(IRAM_ST_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        idle(6);

        // Random fetch stream with gaps over a freshly loaded region
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            load(0, 32'(4 * i), shadow[i]);
        end
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                en[0] = 1'b0;
                tick();
            end
            w = $urandom_range(0, 15);
            en[0] = 1'b1; raddr[0] = 32'(4 * w + $urandom_range(0, 3));
            push(0, shadow[w], 1'b0, 0);
            tick();
        end
        en[0] = 1'b0;
        idle(4);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
